// File: rtl/audio_source_mixer.sv
// N-channel time-multiplexed audio mixer with per-channel soft gain ramp.
// One MAC per channel per sample, then arithmetic shift and saturate.
module audio_source_mixer #(
  parameter int N_CH = 4,
  parameter int DW   = 24,
  parameter int GW   = 4,
  parameter int GF   = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sample_valid_i,
  input  logic [N_CH*DW-1:0]   ch_data_i,
  input  logic [N_CH*GW-1:0]   ch_gain_i,
  input  logic [N_CH-1:0]      ch_en_i,
  input  logic                 clr_overrun_i,
  output logic [DW-1:0]        mix_data_o,
  output logic                 mix_valid_o,
  output logic                 clip_o,
  output logic                 busy_o,
  output logic                 overrun_o
);

  localparam int PW = DW + GW + 1;
  localparam int AW = PW + $clog2(N_CH);
  localparam int IW = $clog2(N_CH);

  localparam logic signed [AW-1:0] SMAX =
    {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN =
    {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_ACCUM, S_SAT, S_OUT
  } state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic signed [DW-1:0]   data_q [N_CH];
  logic signed [DW-1:0]   data_d [N_CH];
  logic [GW-1:0]          tgt_q  [N_CH];
  logic [GW-1:0]          tgt_d  [N_CH];
  logic [GW-1:0]          gain_q [N_CH];
  logic [GW-1:0]          gain_d [N_CH];
  logic [DW-1:0]          mix_q, mix_d;
  logic                   clip_q, clip_d;
  logic                   ovr_q, ovr_d;

  logic                   accept;
  logic                   drop;
  logic signed [PW-1:0]   dext, gext, prod;
  logic signed [AW-1:0]   shifted;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    data_d  = data_q;
    tgt_d   = tgt_q;
    gain_d  = gain_q;
    mix_d   = mix_q;
    clip_d  = clip_q;
    ovr_d   = ovr_q;

    accept  = sample_valid_i &&
              (state_q == S_IDLE || state_q == S_OUT);
    drop    = sample_valid_i &&
              (state_q == S_ACCUM || state_q == S_SAT);

    // gain is unsigned, so it is zero-extended into the signed product
    dext    = PW'(data_q[idx_q]);
    gext    = PW'(gain_q[idx_q]);
    prod    = dext * gext;
    shifted = acc_q >>> GF;

    if (clr_overrun_i) ovr_d = 1'b0;
    if (drop)          ovr_d = 1'b1;

    unique case (state_q)
      S_ACCUM: begin
        acc_d = acc_q + AW'(prod);
        if (gain_q[idx_q] < tgt_q[idx_q])
          gain_d[idx_q] = gain_q[idx_q] + GW'(1);
        else if (gain_q[idx_q] > tgt_q[idx_q])
          gain_d[idx_q] = gain_q[idx_q] - GW'(1);
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(N_CH - 1))
          state_d = S_SAT;
      end
      S_SAT: begin
        if (shifted > SMAX) begin
          mix_d  = SMAX[DW-1:0];
          clip_d = 1'b1;
        end else if (shifted < SMIN) begin
          mix_d  = SMIN[DW-1:0];
          clip_d = 1'b1;
        end else begin
          mix_d  = shifted[DW-1:0];
          clip_d = 1'b0;
        end
        state_d = S_OUT;
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      for (int c = 0; c < N_CH; c++) begin
        data_d[c] = ch_data_i[c*DW +: DW];
        tgt_d[c]  = ch_en_i[c] ? ch_gain_i[c*GW +: GW] : '0;
      end
      acc_d   = '0;
      idx_d   = '0;
      state_d = S_ACCUM;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      mix_q   <= '0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        data_q[c] <= '0;
        tgt_q[c]  <= '0;
        gain_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      mix_q   <= mix_d;
      clip_q  <= clip_d;
      ovr_q   <= ovr_d;
      data_q  <= data_d;
      tgt_q   <= tgt_d;
      gain_q  <= gain_d;
    end
  end

  assign mix_data_o  = mix_q;
  assign clip_o      = clip_q;
  assign mix_valid_o = (state_q == S_OUT);
  assign busy_o      = (state_q == S_ACCUM) || (state_q == S_SAT);
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_audio_source_mixer.sv
// Directed bench for audio_source_mixer: ramp, saturation, timing,
// overrun and mid-operation reset with hand-computed expectations.
module tb_audio_source_mixer;

  localparam int N_CH = 4;
  localparam int DW   = 24;
  localparam int GW   = 4;
  localparam int GF   = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sv  = 1'b0;
  logic [N_CH*DW-1:0] data = '0;
  logic [N_CH*GW-1:0] gain = '0;
  logic [N_CH-1:0]    en   = '0;
  logic               clr  = 1'b0;
  logic [DW-1:0]      mix_data_o;
  logic               mix_valid_o, clip_o, busy_o, overrun_o;

  int n_vec = 0;
  int n_bad = 0;

  audio_source_mixer #(
    .N_CH(N_CH), .DW(DW), .GW(GW), .GF(GF)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .sample_valid_i (sv),
    .ch_data_i      (data),
    .ch_gain_i      (gain),
    .ch_en_i        (en),
    .clr_overrun_i  (clr),
    .mix_data_o     (mix_data_o),
    .mix_valid_o    (mix_valid_o),
    .clip_o         (clip_o),
    .busy_o         (busy_o),
    .overrun_o      (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Strobe once from IDLE, wait for the output pulse, return to IDLE.
  task automatic sample(output logic [DW-1:0] y, output logic c);
    sv = 1'b1;
    tick();
    sv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mix_valid_o) break;
      tick();
    end
    if (!mix_valid_o) chk("valid_timeout", 32'd0, 32'd1);
    y = mix_data_o;
    c = clip_o;
    tick();
  endtask

  logic [DW-1:0] y;
  logic          c;
  logic [DW-1:0] e;
  int            nvalid;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_data",  32'(mix_data_o),  32'd0);
    chk("rst_valid", 32'(mix_valid_o), 32'd0);
    chk("rst_clip",  32'(clip_o),      32'd0);
    chk("rst_busy",  32'(busy_o),      32'd0);
    chk("rst_ovr",   32'(overrun_o),   32'd0);

    // Ramp-up: 0,125,...,1000
    data[0*DW +: DW] = 24'd1000;
    gain[0*GW +: GW] = 4'd8;
    en = 4'b0001;
    for (int g = 0; g <= 8; g++) begin
      sample(y, c);
      chk($sformatf("ramp_up%0d", g), 32'(y), 32'(125 * g));
      chk($sformatf("ramp_up_clip%0d", g), 32'(c), 32'd0);
    end

    // Ramp-down: 1000..125 then hold at 0
    en = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      sample(y, c);
      chk($sformatf("ramp_dn%0d", i), 32'(y),
          (i < 8) ? 32'(1000 - 125 * i) : 32'd0);
    end

    // Latency / throughput: back-to-back accept in OUT
    sv = 1'b1;
    tick();
    sv = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 6; k++) begin
        chk($sformatf("lat%0d_valid_k%0d", r, k),
            32'(mix_valid_o), 32'(k == 6));
        chk($sformatf("lat%0d_busy_k%0d", r, k),
            32'(busy_o), 32'(k < 6));
        if (k == 6 && r == 0) sv = 1'b1;
        tick();
        sv = 1'b0;
      end
    end
    chk("lat_ovr", 32'(overrun_o), 32'd0);

    // Overrun: second strobe in ACCUM is dropped
    sv = 1'b1;
    tick();
    sv = 1'b0;
    nvalid = 0;
    for (int k = 1; k <= 11; k++) begin
      if (mix_valid_o) nvalid++;
      if (k == 6) chk("ovr_valid_k6", 32'(mix_valid_o), 32'd1);
      if (k == 3) chk("ovr_set_k3",   32'(overrun_o),   32'd1);
      if (k == 10) chk("ovr_hold_k10", 32'(overrun_o),  32'd1);
      if (k == 11) chk("ovr_clr_k11",  32'(overrun_o),  32'd0);
      sv  = (k == 2);
      clr = (k == 10);
      tick();
      sv  = 1'b0;
      clr = 1'b0;
    end
    chk("ovr_nvalid", 32'(nvalid), 32'd1);

    // Mid-operation reset
    en = 4'b0001;
    sample(y, c);
    chk("mid_pre0", 32'(y), 32'd0);
    sample(y, c);
    chk("mid_pre1", 32'(y), 32'd125);
    sv = 1'b1;
    tick();
    sv = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_data",  32'(mix_data_o), 32'd0);
    chk("mid_busy",  32'(busy_o),     32'd0);
    chk("mid_clip",  32'(clip_o),     32'd0);
    chk("mid_ovr",   32'(overrun_o),  32'd0);
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      if (mix_valid_o) nvalid++;
      tick();
    end
    chk("mid_novalid", 32'(nvalid), 32'd0);
    sample(y, c);
    chk("mid_restart", 32'(y), 32'd0);

    // Positive / negative saturation with all channels at gain 15
    do_reset();
    en = 4'b1111;
    for (int ch = 0; ch < N_CH; ch++) begin
      data[ch*DW +: DW] = 24'h7FFFFF;
      gain[ch*GW +: GW] = 4'd15;
    end
    for (int i = 0; i < 16; i++) sample(y, c);
    chk("sat_pos",      32'(y), 32'h7FFFFF);
    chk("sat_pos_clip", 32'(c), 32'd1);
    for (int ch = 0; ch < N_CH; ch++) data[ch*DW +: DW] = 24'h800000;
    sample(y, c);
    chk("sat_neg",      32'(y), 32'h800000);
    chk("sat_neg_clip", 32'(c), 32'd1);

    // Full-scale at unity gain does not clip
    do_reset();
    data = '0;
    gain = '0;
    en   = 4'b0001;
    data[0*DW +: DW] = 24'h7FFFFF;
    gain[0*GW +: GW] = 4'd8;
    for (int i = 0; i < 9; i++) sample(y, c);
    chk("fs_unity",      32'(y), 32'h7FFFFF);
    chk("fs_unity_clip", 32'(c), 32'd0);

    // Shift truncates toward -inf: -9/8 -> -2
    data[0*DW +: DW] = 24'hFFFFFF;
    data[1*DW +: DW] = 24'hFFFFFF;
    gain[1*GW +: GW] = 4'd1;
    en = 4'b0011;
    sample(y, c);
    e = 24'hFFFFFF;
    chk("neg_m8", 32'(y), 32'(e));
    sample(y, c);
    e = 24'hFFFFFE;
    chk("neg_m9", 32'(y), 32'(e));
    chk("neg_clip", 32'(c), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
